// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel pipeline: window bus geometry and slice offsets.
package sobel_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned WIN_W = 9 * PIX_W;

  localparam int unsigned P00_LSB = 8 * PIX_W;
  localparam int unsigned P01_LSB = 7 * PIX_W;
  localparam int unsigned P02_LSB = 6 * PIX_W;
  localparam int unsigned P10_LSB = 5 * PIX_W;
  localparam int unsigned P11_LSB = 4 * PIX_W;
  localparam int unsigned P12_LSB = 3 * PIX_W;
  localparam int unsigned P20_LSB = 2 * PIX_W;
  localparam int unsigned P21_LSB = 1 * PIX_W;
  localparam int unsigned P22_LSB = 0;

  // LSB of p[r][c] on a window bus of pixel width pw (p00 occupies the top slice).
  function automatic int unsigned win_lsb(input int unsigned r, input int unsigned c,
                                          input int unsigned pw);
    return (8 - (3 * r + c)) * pw;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of storage: registered write, read returns the pre-write contents.
module sobel_line_buffer #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  // No reset: stale contents are never used before a full row has been written.
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream to 3x3 neighbourhood windows, one per interior pixel.
module sobel_window_gen #(
  parameter int unsigned IMG_WIDTH  = 128,
  parameter int unsigned IMG_HEIGHT = 128,
  parameter int unsigned PIX_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic               pix_valid,
  input  logic               pix_sof,
  output logic               pix_ready,
  output logic [9*PIX_W-1:0] win_out,
  output logic               win_valid,
  input  logic               win_ready,
  output logic               frame_done
);
  import sobel_pkg::*;

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]      col_q, col_d, eff_col;
  logic [RW-1:0]      row_q, row_d, eff_row;
  logic [PIX_W-1:0]   lb0_rd, lb1_rd;
  logic [PIX_W-1:0]   win_q [3][3];
  logic [PIX_W-1:0]   win_d [3][3];
  logic [9*PIX_W-1:0] win_out_q, win_out_d;
  logic               win_valid_q, win_valid_d;
  logic               frame_done_q, frame_done_d;
  logic               accept;

  assign pix_ready  = !win_valid_q || win_ready;
  assign accept     = pix_valid && pix_ready;
  assign eff_col    = pix_sof ? '0 : col_q;
  assign eff_row    = pix_sof ? '0 : row_q;
  assign win_out    = win_out_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb0 (
    .clk_i   (clk),
    .we_i    (accept),
    .addr_i  (eff_col),
    .wdata_i (pix_in),
    .rdata_o (lb0_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb1 (
    .clk_i   (clk),
    .we_i    (accept),
    .addr_i  (eff_col),
    .wdata_i (lb0_rd),
    .rdata_o (lb1_rd)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_out_d    = win_out_q;
    win_valid_d  = win_valid_q && !win_ready;
    frame_done_d = 1'b0;
    if (accept) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = pix_in;
      if (eff_col == LAST_COL) begin
        col_d        = '0;
        row_d        = (eff_row == LAST_ROW) ? '0 : eff_row + RW'(1);
        frame_done_d = (eff_row == LAST_ROW);
      end else begin
        col_d = eff_col + CW'(1);
        row_d = eff_row;
      end
      // Gating on col >= 2 drops the two columns left over from the previous row.
      if (eff_row >= RW'(2) && eff_col >= CW'(2)) begin
        win_valid_d = 1'b1;
        for (int unsigned r = 0; r < 3; r++) begin
          for (int unsigned c = 0; c < 3; c++) begin
            win_out_d[win_lsb(r, c, PIX_W) +: PIX_W] = win_d[r][c];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '{default: '0};
      win_out_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_out_q    <= win_out_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen on a 4x4 image against an image-array reference model.
module tb_sobel_window_gen;
  import sobel_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        pix_sof;
  logic        pix_ready;
  logic [71:0] win_out;
  logic        win_valid;
  logic        win_ready;
  logic        frame_done;

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_ready  (pix_ready),
    .win_out    (win_out),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          nwin = 0;
  int          nfd = 0;
  logic [7:0]  img [H][W];
  int          rpos = 0;
  int          cpos = 0;
  logic [71:0] expq [$];
  bit          exp_valid = 1'b0;
  bit          exp_fd = 1'b0;
  logic [71:0] first_win;
  logic [71:0] last_win;
  bit          got_first;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic step(input bit pv, input bit sof, input logic [7:0] px, input bit wr,
                      output bit acc);
    bit          emit;
    logic [71:0] w;
    pix_valid = pv;
    pix_sof   = sof;
    pix_in    = px;
    win_ready = wr;
    @(negedge clk);
    chk("win_valid", {71'd0, win_valid}, {71'd0, exp_valid});
    chk("pix_ready", {71'd0, pix_ready}, {71'd0, !exp_valid || wr});
    chk("frame_done", {71'd0, frame_done}, {71'd0, exp_fd});
    if (frame_done) nfd++;
    if (exp_valid) begin
      if (expq.size() == 0) begin
        chk("spurious_window", {71'd0, win_valid}, 72'd0);
      end else begin
        chk("win_out", win_out, expq[0]);
        chk("centre", {64'd0, win_out[P11_LSB +: 8]}, {64'd0, expq[0][P11_LSB +: 8]});
      end
    end
    if (exp_valid && wr && expq.size() > 0) begin
      void'(expq.pop_front());
      nwin++;
      if (!got_first) begin
        first_win = win_out;
        got_first = 1'b1;
      end
      last_win = win_out;
    end
    acc    = pv && (!exp_valid || wr);
    exp_fd = 1'b0;
    emit   = 1'b0;
    if (acc) begin
      if (sof) begin
        rpos = 0;
        cpos = 0;
      end
      img[rpos][cpos] = px;
      if (rpos >= 2 && cpos >= 2) begin
        w = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            w = {w[63:0], img[rpos-2+i][cpos-2+j]};
        expq.push_back(w);
        emit = 1'b1;
      end
      exp_fd = (rpos == H - 1) && (cpos == W - 1);
      cpos++;
      if (cpos == W) begin
        cpos = 0;
        rpos = (rpos == H - 1) ? 0 : rpos + 1;
      end
    end
    exp_valid = emit || (exp_valid && !wr);
    @(posedge clk);
    #1;
  endtask

  // mode 0: steady; 1: stall win_ready 5 cycles on first window; 2: toggling valid, random ready
  task automatic run_frame(input int npix, input bit sof_first, input int mode, input bit rnd);
    int         p = 0;
    int         cycles = 0;
    int         stall = 0;
    bit         pv, wr, acc;
    logic [7:0] px;
    px = rnd ? 8'($urandom) : 8'(0);
    while (p < npix && cycles < 400) begin
      pv = 1'b1;
      wr = 1'b1;
      if (mode == 2) begin
        pv = (cycles % 2) == 0;
        wr = 1'($urandom_range(0, 1));
      end
      if (mode == 1 && exp_valid && stall < 5) begin
        wr = 1'b0;
        stall++;
      end
      step(pv, sof_first && p == 0, rnd ? px : 8'(p % 16), wr, acc);
      if (acc) begin
        p++;
        px = rnd ? 8'($urandom) : 8'(0);
      end
      cycles++;
    end
    if (p < npix) chk("frame_timeout", 72'(p), 72'(npix));
  endtask

  task automatic drain();
    int n = 0;
    bit acc;
    while ((exp_valid || n == 0) && n < 20) begin
      step(1'b0, 1'b0, 8'd0, 1'b1, acc);
      n++;
    end
    chk("drain_valid", {71'd0, win_valid}, 72'd0);
    chk("leftover", 72'(expq.size()), 72'd0);
  endtask

  int w0, f0;

  initial begin
    reset = 1'b1; pix_in = '0; pix_valid = 1'b0; pix_sof = 1'b0; win_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {71'd0, win_valid}, 72'd0);
    chk("rst_win_out", win_out, 72'd0);
    chk("rst_frame_done", {71'd0, frame_done}, 72'd0);
    chk("rst_ready", {71'd0, pix_ready}, 72'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Plain frame
    w0 = nwin; f0 = nfd; got_first = 1'b0;
    run_frame(16, 1'b1, 0, 1'b0);
    drain();
    chk("s1_windows", 72'(nwin - w0), 72'd4);
    chk("s1_frame_done", 72'(nfd - f0), 72'd1);
    chk("s1_first_literal", first_win, 72'h00_01_02_04_05_06_08_09_0A);
    chk("s1_last_literal", last_win, 72'h05_06_07_09_0A_0B_0D_0E_0F);

    // Backpressure
    w0 = nwin; got_first = 1'b0;
    run_frame(16, 1'b1, 1, 1'b0);
    drain();
    chk("s2_windows", 72'(nwin - w0), 72'd4);
    chk("s2_first_literal", first_win, 72'h00_01_02_04_05_06_08_09_0A);

    // Back-to-back frames
    w0 = nwin; f0 = nfd;
    run_frame(16, 1'b1, 0, 1'b0);
    run_frame(16, 1'b1, 0, 1'b0);
    drain();
    chk("s3_windows", 72'(nwin - w0), 72'd8);
    chk("s3_frame_done", 72'(nfd - f0), 72'd2);

    // Mid-frame sof
    w0 = nwin;
    run_frame(9, 1'b1, 0, 1'b1);
    run_frame(16, 1'b1, 0, 1'b0);
    drain();
    chk("s4_windows", 72'(nwin - w0), 72'd4);

    // Asynchronous reset mid-frame while a window is pending
    run_frame(11, 1'b1, 0, 1'b0);
    chk("pre_reset_valid", {71'd0, win_valid}, 72'd1);
    pix_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", {71'd0, win_valid}, 72'd0);
    chk("async_rst_win_out", win_out, 72'd0);
    expq.delete();
    exp_valid = 1'b0; exp_fd = 1'b0; rpos = 0; cpos = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    w0 = nwin; got_first = 1'b0;
    run_frame(16, 1'b0, 0, 1'b0);
    drain();
    chk("s5_windows", 72'(nwin - w0), 72'd4);
    chk("s5_first_literal", first_win, 72'h00_01_02_04_05_06_08_09_0A);

    // Toggling valid with random ready, then random pixel frames
    w0 = nwin; got_first = 1'b0;
    run_frame(16, 1'b1, 2, 1'b0);
    drain();
    chk("s6_windows", 72'(nwin - w0), 72'd4);
    chk("s6_last_literal", last_win, 72'h05_06_07_09_0A_0B_0D_0E_0F);
    w0 = nwin;
    for (int k = 0; k < 4; k++) run_frame(16, 1'b1, k % 3, 1'b1);
    drain();
    chk("s7_windows", 72'(nwin - w0), 72'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
